imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Instruction-memory line responder. Accepts one line request
//               at a time from the instruction cache, returns the addressed
//               line after a fixed latency and holds it until acknowledged.
//               The backing store can be written at any time via load_*.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int MEM_ADDRESS_LEN   = 12,
    parameter int ICACHE_LINE_WIDTH = 128,
    parameter int MEM_LINES         = 256,
    parameter int LATENCY           = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reqI_mem,
    input  logic [MEM_ADDRESS_LEN-1:0]   reqAddrI_mem,
    input  logic                         data_filled_ack,
    input  logic                         load_en,
    input  logic [MEM_ADDRESS_LEN-1:0]   load_addr,
    input  logic [ICACHE_LINE_WIDTH-1:0] load_data,
    output logic [ICACHE_LINE_WIDTH-1:0] instr_from_mem,
    output logic                         mem_data_rdy,
    output logic                         busy
);

    localparam int         c_IDX_W  = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [3:0]                   r_cnt;
    logic [3:0]                   w_cnt_nxt;
    logic                         w_accept;
    logic                         w_capture;
    logic [c_IDX_W-1:0]           r_idx;
    logic [ICACHE_LINE_WIDTH-1:0] r_data;
    logic [ICACHE_LINE_WIDTH-1:0] r_mem [MEM_LINES];

    // Line index: drop the 16-byte offset, then wrap into the store depth.
    function automatic logic [c_IDX_W-1:0] f_line_index(input logic [MEM_ADDRESS_LEN-1:0] addr);
        logic [31:0] w_line;
        w_line = 32'(addr >> 4) % 32'(MEM_LINES);
        return w_line[c_IDX_W-1:0];
    endfunction

    // Backing store write port; contents survive reset, writes blocked during it.
    always_ff @(posedge clk) begin
        if (!reset && load_en) begin
            r_mem[f_line_index(load_addr)] <= load_data;
        end
    end

    // State, latency counter and latched request index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx <= f_line_index(reqAddrI_mem);
            end
        end
    end

    // Returned line register; the store read sees pre-write contents on the capture edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_capture) begin
            r_data <= r_mem[r_idx];
        end
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reqI_mem) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = c_LAT_M1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_READY;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_READY: begin
                if (data_filled_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign instr_from_mem = r_data;
    assign mem_data_rdy   = (r_state == S_READY);
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire
